// File: rtl/multiplier_nbit_seq.sv
// Sequential shift-and-add multiplier: retires BITS_PER_CYCLE multiplier bits per cycle,
// with signed operands handled as magnitudes plus a result sign.

module adder_nbit_cin #(
  parameter int N         = 8,
  parameter int IMPL_TYPE = 0
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum
);
  // Sum is modulo 2^N; carry-out is never needed by the multiplier.
  generate
    if (IMPL_TYPE == 1) begin : g_ripple
      logic [N-1:0] w_c;
      assign w_c[0] = i_cin;
      for (genvar i = 0; i < N; i++) begin : g_bit
        assign o_sum[i] = i_a[i] ^ i_b[i] ^ w_c[i];
        if (i < N - 1) begin : g_carry
          assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
      end
    end else begin : g_behav
      assign o_sum = i_a + i_b + {{(N-1){1'b0}}, i_cin};
    end
  endgenerate
endmodule

module multiplier_nbit_seq #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int IMPL_TYPE      = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   P,
  output logic                 busy,
  output logic [1:0]           dbg_state
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends combinationally on ready, and P holds while out_valid waits.
  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic            r_sign;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_p;
  logic            r_out_valid;

  logic [WIDTH-1:0] w_neg_a;
  logic [WIDTH-1:0] w_neg_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [PW-1:0]    w_sum [0:BITS_PER_CYCLE];
  logic [PW-1:0]    w_acc_next;
  logic [PW-1:0]    w_acc_neg;

  adder_nbit_cin #(.N(WIDTH), .IMPL_TYPE(IMPL_TYPE)) u_neg_a (
    .i_a(~A), .i_b({WIDTH{1'b0}}), .i_cin(1'b1), .o_sum(w_neg_a)
  );
  adder_nbit_cin #(.N(WIDTH), .IMPL_TYPE(IMPL_TYPE)) u_neg_b (
    .i_a(~B), .i_b({WIDTH{1'b0}}), .i_cin(1'b1), .o_sum(w_neg_b)
  );

  assign w_mag_a = (signed_mode && A[WIDTH-1]) ? w_neg_a : A;
  assign w_mag_b = (signed_mode && B[WIDTH-1]) ? w_neg_b : B;

  // One adder per digit bit; r_mcand already carries the digit's weight.
  assign w_sum[0] = r_acc;
  generate
    for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_pp
      logic [PW-1:0] w_addend;
      assign w_addend = r_mplier[j] ? (r_mcand << j) : {PW{1'b0}};
      adder_nbit_cin #(.N(PW), .IMPL_TYPE(IMPL_TYPE)) u_add (
        .i_a(w_sum[j]), .i_b(w_addend), .i_cin(1'b0), .o_sum(w_sum[j+1])
      );
    end
  endgenerate
  assign w_acc_next = w_sum[BITS_PER_CYCLE];

  adder_nbit_cin #(.N(PW), .IMPL_TYPE(IMPL_TYPE)) u_neg_p (
    .i_a(~w_acc_next), .i_b({PW{1'b0}}), .i_cin(1'b1), .o_sum(w_acc_neg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_sign      <= 1'b0;
      r_cnt       <= '0;
      r_p         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_sign   <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << BITS_PER_CYCLE;
          r_mplier <= r_mplier >> BITS_PER_CYCLE;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CW'(STEPS - 1)) begin
            r_p         <= r_sign ? w_acc_neg : w_acc_next;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign P         = r_p;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_multiplier_nbit_seq.sv
// Directed checks on an 8-bit/2-bit-per-cycle instance plus randomized checks on nine
// WIDTH x BITS_PER_CYCLE configurations against an arithmetic reference model.

module tb_multiplier_nbit_seq;
  int total = 0;
  int bad   = 0;
  int n_done = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed instance: WIDTH=8, BITS_PER_CYCLE=2 ----------------
  localparam int DSTEPS = 4;
  logic        d_rst_n = 1'b0;
  logic        d_in_valid = 1'b0, d_in_ready, d_sm = 1'b0;
  logic [7:0]  d_a = '0, d_b = '0;
  logic        d_out_valid, d_out_ready = 1'b0, d_busy;
  logic [15:0] d_p;
  logic [1:0]  d_dbg;

  multiplier_nbit_seq #(.WIDTH(8), .BITS_PER_CYCLE(2), .IMPL_TYPE(0)) u_dut (
    .clk(clk), .rst_n(d_rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .A(d_a), .B(d_b), .signed_mode(d_sm), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .P(d_p), .busy(d_busy), .dbg_state(d_dbg)
  );

  task automatic d_accept(input logic [7:0] a, input logic [7:0] b, input logic sm);
    @(negedge clk);
    d_a = a; d_b = b; d_sm = sm; d_in_valid = 1'b1;
    chk(64'(d_in_ready), 64'd1, "in_ready_before_accept");
    @(posedge clk); #1;
    d_in_valid = 1'b0;
  endtask

  // Counts edges after the accepting edge until out_valid is seen.
  task automatic d_wait_valid(output int lat);
    lat = 0;
    while (!d_out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic d_op(input logic [7:0] a, input logic [7:0] b, input logic sm,
                      input logic [15:0] exp, input string tag);
    int lat;
    d_accept(a, b, sm);
    d_wait_valid(lat);
    chk(64'(lat), 64'(DSTEPS), {tag, "_latency"});
    chk(64'(d_p), 64'(exp), {tag, "_P"});
    d_out_ready = 1'b1;
    @(posedge clk); #1;
    d_out_ready = 1'b0;
    chk(64'({d_out_valid, d_in_ready, d_busy}), 64'b010, {tag, "_back_to_idle"});
  endtask

  // ---------------- randomized instances ----------------
  logic rnd_rst_n = 1'b0;
  localparam int NOPS = 1112;

  for (genvar g = 0; g < 9; g++) begin : g_cfg
    localparam int W   = 8 << (g / 3);
    localparam int BPC = 1 << (g % 3);
    localparam int STP = W / BPC;

    logic            iv = 1'b0, ir, sm = 1'b0, ov, ordy = 1'b0, bsy;
    logic [W-1:0]    a = '0, b = '0;
    logic [2*W-1:0]  p;
    logic [1:0]      dbg;

    multiplier_nbit_seq #(.WIDTH(W), .BITS_PER_CYCLE(BPC), .IMPL_TYPE(g % 2)) u_dut (
      .clk(clk), .rst_n(rnd_rst_n), .in_valid(iv), .in_ready(ir),
      .A(a), .B(b), .signed_mode(sm), .out_valid(ov),
      .out_ready(ordy), .P(p), .busy(bsy), .dbg_state(dbg)
    );

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic s);
      logic [2*W-1:0] ex, ey;
      ex = s ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
      ey = s ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
      return ex * ey;
    endfunction

    function automatic logic [W-1:0] pick();
      logic [63:0] r;
      r = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0:       return '0;
        1:       return '1;
        2:       return {1'b1, {(W-1){1'b0}}};
        3:       return {1'b0, {(W-1){1'b1}}};
        default: return r[W-1:0];
      endcase
    endfunction

    initial begin
      logic [W-1:0]   ea, eb;
      logic           es;
      logic [2*W-1:0] ep;
      int             lat;
      wait (rnd_rst_n === 1'b1);
      @(posedge clk); #1;
      for (int k = 0; k < NOPS; k++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        ea = pick(); eb = pick(); es = 1'($urandom_range(0, 1));
        ep = ref_mul(ea, eb, es);
        a = ea; b = eb; sm = es; iv = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        // Junk on in_valid/A/B and out_ready while busy must be ignored.
        while (!ov && lat < STP + 8) begin
          iv = 1'($urandom_range(0, 1)); a = pick(); b = pick(); sm = 1'($urandom_range(0, 1));
          ordy = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
          lat++;
        end
        iv = 1'b0; ordy = 1'b0;
        chk(64'(lat), 64'(STP), $sformatf("rnd_w%0d_b%0d_latency", W, BPC));
        chk(64'(p), 64'(ep), $sformatf("rnd_w%0d_b%0d_P a=%0h b=%0h s=%0d", W, BPC, ea, eb, es));
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        chk(64'({ov, ir}), 64'b01, $sformatf("rnd_w%0d_b%0d_release", W, BPC));
      end
      n_done++;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] held;
    int lat, t_prev, t_now, cyc;
    logic prev_ov;

    #12;
    chk(64'({d_in_ready, d_out_valid, d_busy}), 64'b100, "reset_flags");
    chk(64'(d_p), 64'd0, "reset_P");
    @(negedge clk); d_rst_n = 1'b1; rnd_rst_n = 1'b1;

    d_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, "umax_x_umax");
    d_op(8'h80, 8'h80, 1'b1, 16'h4000, "smin_x_smin");
    d_op(8'hFD, 8'h07, 1'b1, 16'hFFEB, "m3_x_7");
    d_op(8'h00, 8'h00, 1'b0, 16'h0000, "zero_x_zero");
    d_op(8'hFB, 8'h00, 1'b1, 16'h0000, "m5_x_zero");
    d_op(8'hFF, 8'hFF, 1'b1, 16'h0001, "m1_x_m1");
    d_op(8'h7F, 8'h80, 1'b1, 16'hC080, "smax_x_smin");
    d_op(8'h80, 8'hFF, 1'b0, 16'h7F80, "u128_x_u255");

    // Backpressure: result held for 10 cycles while new operands are offered.
    d_accept(8'h0C, 8'h0B, 1'b0);
    d_wait_valid(lat);
    chk(64'(lat), 64'(DSTEPS), "bp_latency");
    held = d_p;
    chk(64'(held), 64'd132, "bp_P");
    for (int i = 0; i < 10; i++) begin
      d_in_valid = i[0]; d_a = 8'h11; d_b = 8'h22;
      @(posedge clk); #1;
      chk(64'({d_out_valid, d_in_ready, d_p}), 64'({2'b10, 16'd132}), "bp_hold");
    end
    d_in_valid = 1'b0; d_out_ready = 1'b1;
    @(posedge clk); #1;
    d_out_ready = 1'b0;
    chk(64'({d_out_valid, d_in_ready}), 64'b01, "bp_release");
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (d_out_valid || d_busy) cyc++;
    end
    chk(64'(cyc), 64'd0, "bp_single_transfer");

    // Asynchronous reset two cycles into BUSY.
    d_accept(8'h09, 8'h09, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk(64'(d_busy), 64'd1, "mid_busy_before_reset");
    #2 d_rst_n = 1'b0;
    #1;
    chk(64'({d_in_ready, d_out_valid, d_busy}), 64'b100, "async_reset_flags");
    chk(64'(d_p), 64'd0, "async_reset_P");
    @(negedge clk); d_rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (d_out_valid || d_busy) cyc++;
    end
    chk(64'(cyc), 64'd0, "no_valid_after_reset");
    d_op(8'd3, 8'd5, 1'b0, 16'd15, "after_reset_3x5");

    // Throughput with in_valid and out_ready held high.
    @(negedge clk);
    d_a = 8'd6; d_b = 8'd7; d_sm = 1'b0; d_in_valid = 1'b1; d_out_ready = 1'b1;
    t_prev = -1; prev_ov = 1'b0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (d_out_valid && !prev_ov) begin
        chk(64'(d_p), 64'd42, "tput_P");
        t_now = i;
        if (t_prev >= 0) chk(64'(t_now - t_prev), 64'(DSTEPS + 2), "tput_period");
        t_prev = t_now;
        cyc++;
      end
      prev_ov = d_out_valid;
    end
    chk(64'(cyc >= 4), 64'd1, "tput_results_seen");
    d_in_valid = 1'b0; d_out_ready = 1'b0;

    for (int i = 0; i < 80000 && n_done < 9; i++) @(posedge clk);
    chk(64'(n_done), 64'd9, "random_configs_finished");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
